// File: rtl/simon_seq_checker_pkg.sv
// Shared types and constants for the Simon sequence checker: FSM states,
// colour type, LFSR taps and the substitute seed.
package simon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_BTN = 2'd1,
    ST_PASS     = 2'd2,
    ST_FAIL     = 2'd3
  } state_e;

  typedef logic [1:0] color_t;

  localparam int unsigned TAP_A = 31;
  localparam int unsigned TAP_B = 21;
  localparam int unsigned TAP_C = 1;
  localparam int unsigned TAP_D = 0;

  localparam logic [31:0] LFSR_SEED_DEFAULT = 32'h2048FAFA;

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return {s[30:0], s[TAP_A] ^ s[TAP_B] ^ s[TAP_C] ^ s[TAP_D]};
  endfunction

endpackage

// File: rtl/simon_seq_checker_lfsr.sv
// 32-bit Fibonacci LFSR holding the colour sequence; load has priority
// over advance.
module seq_lfsr
  import simon_pkg::*;
#(
  parameter logic [31:0] RESET_VAL = 32'h2048FAFA
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic [31:0] load_val_i,
  input  logic        adv_i,
  output logic [31:0] state_o
);

  logic [31:0] lfsr_q;
  logic [31:0] lfsr_d;

  // next LFSR value
  always_comb begin
    lfsr_d = lfsr_q;
    if (load_i) begin
      lfsr_d = load_val_i;
    end else if (adv_i) begin
      lfsr_d = lfsr_next(lfsr_q);
    end else begin
      lfsr_d = lfsr_q;
    end
  end

  // LFSR register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= RESET_VAL;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign state_o = lfsr_q;

endmodule

// File: rtl/simon_seq_checker.sv
// Checks player presses against an LFSR-generated colour sequence of
// level+1 steps, with a per-press timeout; all outputs are registered.
module simon_seq_checker #(
  parameter logic [23:0] TIMEOUT_CYCLES    = 24'd5_000_000,
  parameter logic [31:0] LFSR_SEED_DEFAULT = simon_pkg::LFSR_SEED_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] seed,
  input  logic [4:0]  level,
  input  logic        btn_valid,
  input  logic [1:0]  btn_color,
  output logic        busy,
  output logic [4:0]  step_idx,
  output logic        pass,
  output logic        fail,
  output logic        timeout
);
  import simon_pkg::*;

  state_e      state_q, state_d;
  logic [4:0]  step_q, step_d;
  logic [4:0]  level_q, level_d;
  logic [23:0] tmr_q, tmr_d;
  logic        busy_q, busy_d;
  logic        pass_q, pass_d;
  logic        fail_q, fail_d;
  logic        timeout_q, timeout_d;
  logic        lfsr_load_s;
  logic        lfsr_adv_s;
  logic [31:0] lfsr_load_val_s;
  logic [31:0] lfsr_s;

  assign lfsr_load_val_s = (seed == 32'd0) ? LFSR_SEED_DEFAULT : seed;

  seq_lfsr #(
    .RESET_VAL (LFSR_SEED_DEFAULT)
  ) u_lfsr (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (lfsr_load_s),
    .load_val_i (lfsr_load_val_s),
    .adv_i      (lfsr_adv_s),
    .state_o    (lfsr_s)
  );

  // round control: start overrides everything, press beats timeout expiry
  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    level_d     = level_q;
    tmr_d       = tmr_q;
    timeout_d   = timeout_q;
    pass_d      = 1'b0;
    fail_d      = 1'b0;
    lfsr_load_s = 1'b0;
    lfsr_adv_s  = 1'b0;
    if (start) begin
      state_d     = ST_WAIT_BTN;
      level_d     = level;
      step_d      = 5'd0;
      tmr_d       = 24'd0;
      timeout_d   = 1'b0;
      lfsr_load_s = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_WAIT_BTN: begin
          if (btn_valid) begin
            if (color_t'(btn_color) == color_t'(lfsr_s[1:0])) begin
              if (step_q == level_q) begin
                state_d = ST_PASS;
                pass_d  = 1'b1;
              end else begin
                step_d     = step_q + 5'd1;
                lfsr_adv_s = 1'b1;
                tmr_d      = 24'd0;
              end
            end else begin
              state_d   = ST_FAIL;
              fail_d    = 1'b1;
              timeout_d = 1'b0;
            end
          end else if (tmr_q == TIMEOUT_CYCLES - 24'd1) begin
            state_d   = ST_FAIL;
            fail_d    = 1'b1;
            timeout_d = 1'b1;
          end else begin
            tmr_d = tmr_q + 24'd1;
          end
        end
        ST_PASS, ST_FAIL: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
    busy_d = (state_d != ST_IDLE);
  end

  // state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      step_q    <= 5'd0;
      level_q   <= 5'd0;
      tmr_q     <= 24'd0;
      busy_q    <= 1'b0;
      pass_q    <= 1'b0;
      fail_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      level_q   <= level_d;
      tmr_q     <= tmr_d;
      busy_q    <= busy_d;
      pass_q    <= pass_d;
      fail_q    <= fail_d;
      timeout_q <= timeout_d;
    end
  end

  assign busy     = busy_q;
  assign step_idx = step_q;
  assign pass     = pass_q;
  assign fail     = fail_q;
  assign timeout  = timeout_q;

endmodule

// File: tb/tb_simon_seq_checker.sv
// Directed and randomized bench for simon_seq_checker, compared against a
// round-level model that expands the colour sequence up front.
module tb_simon_seq_checker;

  localparam int T = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] seed = 32'd0;
  logic [4:0]  level = 5'd0;
  logic        btn_valid = 1'b0;
  logic [1:0]  btn_color = 2'd0;
  logic        busy, pass, fail, timeout;
  logic [4:0]  step_idx;

  int ncmp = 0;
  int nmis = 0;

  bit         m_active, m_busy, m_pass, m_fail, m_to;
  int         m_step, m_level, m_idle;
  logic [1:0] m_seq [32];

  simon_seq_checker #(
    .TIMEOUT_CYCLES    (24'd16),
    .LFSR_SEED_DEFAULT (32'h2048FAFA)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .seed      (seed),
    .level     (level),
    .btn_valid (btn_valid),
    .btn_color (btn_color),
    .busy      (busy),
    .step_idx  (step_idx),
    .pass      (pass),
    .fail      (fail),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ncmp++;
    assert (got === exp) else begin
      nmis++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_all(input string ctx);
    chk({ctx, ".busy"}, 32'(busy), 32'(m_busy));
    chk({ctx, ".step_idx"}, 32'(step_idx), 32'(m_step));
    chk({ctx, ".pass"}, 32'(pass), 32'(m_pass));
    chk({ctx, ".fail"}, 32'(fail), 32'(m_fail));
    chk({ctx, ".timeout"}, 32'(timeout), 32'(m_to));
  endtask

  // whole colour sequence of a round, expanded from the seed
  task automatic m_load(input logic [31:0] sd);
    logic [31:0] s;
    s = (sd == 32'd0) ? 32'h2048FAFA : sd;
    for (int i = 0; i < 32; i++) begin
      m_seq[i] = s[1:0];
      s = {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
    end
  endtask

  task automatic m_reset();
    m_active = 1'b0; m_busy = 1'b0; m_pass = 1'b0; m_fail = 1'b0; m_to = 1'b0;
    m_step = 0; m_level = 0; m_idle = 0;
  endtask

  task automatic m_upd(input bit st, input logic [31:0] sd, input logic [4:0] lv,
                       input bit bv, input logic [1:0] col);
    m_pass = 1'b0;
    m_fail = 1'b0;
    if (st) begin
      m_load(sd);
      m_active = 1'b1; m_step = 0; m_idle = 0; m_to = 1'b0; m_level = int'(lv);
    end else if (m_active) begin
      if (bv) begin
        if (col == m_seq[m_step]) begin
          if (m_step == m_level) begin
            m_pass = 1'b1; m_active = 1'b0;
          end else begin
            m_step++; m_idle = 0;
          end
        end else begin
          m_fail = 1'b1; m_to = 1'b0; m_active = 1'b0;
        end
      end else if (m_idle == T - 1) begin
        m_fail = 1'b1; m_to = 1'b1; m_active = 1'b0;
      end else begin
        m_idle++;
      end
    end
    m_busy = m_active | m_pass | m_fail;
  endtask

  task automatic cyc(input bit st, input logic [31:0] sd, input logic [4:0] lv,
                     input bit bv, input logic [1:0] col, input string ctx);
    @(negedge clk);
    start = st; seed = sd; level = lv; btn_valid = bv; btn_color = col;
    m_upd(st, sd, lv, bv, col);
    @(posedge clk);
    #1;
    chk_all(ctx);
  endtask

  task automatic go(input logic [31:0] sd, input logic [4:0] lv, input string ctx);
    cyc(1'b1, sd, lv, 1'b0, 2'd0, ctx);
  endtask

  task automatic press(input logic [1:0] col, input string ctx);
    cyc(1'b0, 32'd0, 5'd0, 1'b1, col, ctx);
  endtask

  task automatic idle(input int n, input string ctx);
    for (int i = 0; i < n; i++) cyc(1'b0, 32'd0, 5'd0, 1'b0, 2'd0, ctx);
  endtask

  initial begin
    bit         r_st, r_bv;
    logic [1:0] r_col;
    logic [31:0] r_seed;

    m_reset();
    #3;
    chk_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // first start honoured right after reset release, then 1,3,2,1 -> pass
    cyc(1'b1, 32'd1, 5'd3, 1'b0, 2'd0, "r036.start");
    chk("r036.step0", 32'(step_idx), 32'd0);
    press(2'd1, "r036.p1");
    press(2'd3, "r036.p2");
    press(2'd2, "r036.p3");
    chk("r036.step3", 32'(step_idx), 32'd3);
    press(2'd1, "r036.p4");
    chk("r036.pass", 32'(pass), 32'd1);
    idle(2, "r036.after");

    go(32'd1, 5'd3, "r037.start");
    press(2'd1, "r037.p1");
    press(2'd3, "r037.p2");
    press(2'd0, "r037.p3");
    chk("r037.fail", 32'(fail), 32'd1);
    chk("r037.timeout", 32'(timeout), 32'd0);
    idle(1, "r037.after");
    chk("r037.busy_low", 32'(busy), 32'd0);

    go(32'd1, 5'd0, "r038.start");
    idle(15, "r038.wait");
    chk("r038.no_fail_yet", 32'(fail), 32'd0);
    idle(1, "r038.expire");
    chk("r038.fail", 32'(fail), 32'd1);
    chk("r038.timeout", 32'(timeout), 32'd1);
    idle(2, "r038.after");

    go(32'd0, 5'd0, "r039.start");
    press(2'd2, "r039.p1");
    chk("r039.pass", 32'(pass), 32'd1);
    idle(2, "r039.after");

    go(32'd1, 5'd3, "r040.start");
    press(2'd1, "r040.p1");
    cyc(1'b1, 32'd1, 5'd3, 1'b1, 2'd3, "r040.restart");
    chk("r040.step0", 32'(step_idx), 32'd0);
    press(2'd1, "r040.p1again");
    chk("r040.step1", 32'(step_idx), 32'd1);
    idle(T + 2, "r040.drain");

    r_seed = $urandom;
    go(r_seed, 5'd31, "r029.start");
    for (int i = 0; i < 32; i++) press(m_seq[m_step], "r029.press");
    chk("r029.pass", 32'(pass), 32'd1);
    chk("r029.step31", 32'(step_idx), 32'd31);
    idle(2, "r029.after");

    go(32'd1, 5'd3, "r041.start");
    press(2'd1, "r041.p1");
    press(2'd3, "r041.p2");
    @(negedge clk);
    rst_n = 1'b0;
    m_reset();
    #1;
    chk_all("r041.async");
    @(posedge clk);
    #1;
    chk_all("r041.held");
    @(negedge clk);
    rst_n = 1'b1;
    idle(3, "r041.after");

    for (int n = 0; n < 3000; n++) begin
      r_st  = ($urandom_range(0, 39) == 0);
      r_bv  = ($urandom_range(0, 2) == 0);
      r_col = ($urandom_range(0, 9) < 8) ? m_seq[m_step] : 2'($urandom);
      r_seed = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      cyc(r_st, r_seed, 5'($urandom_range(0, 6)), r_bv, r_col, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nmis);
    $finish;
  end

endmodule

// File: doc/simon_seq_checker.md
SIMON_SEQ_CHECKER -- requirements
Module: simon_seq_checker

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 24'd5_000_000: cycles allowed between accepted presses before timeout.
REQ-002 Parameter LFSR_SEED_DEFAULT, default 32'h2048FAFA: substitute seed used when the seed input is zero.
REQ-003 clk  input  1  single system clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  single-cycle pulse that loads seed and level and begins a check round.
REQ-006 seed  input  32  LFSR seed sampled when start=1.
REQ-007 level  input  5  round length minus one, sampled when start=1; the round expects level+1 presses (1..32).
REQ-008 btn_valid  input  1  single-cycle strobe marking one player press.
REQ-009 btn_color  input  2  colour of the press, qualified by btn_valid.
REQ-010 busy  output  1  high while a round is in progress.
REQ-011 step_idx  output  5  index of the next expected press, 0-based.
REQ-012 pass  output  1  single-cycle pulse when all level+1 presses match.
REQ-013 fail  output  1  single-cycle pulse on a wrong colour or a timeout.
REQ-014 timeout  output  1  valid with fail: 1 = timeout, 0 = wrong colour; held until the next start.

Function
REQ-015 The FSM SHALL have exactly four states: IDLE, WAIT_BTN, PASS and FAIL.
REQ-016 In IDLE with start=1, the block SHALL perform all of the following and enter WAIT_BTN on the next cycle:
- load the LFSR with seed, or with LFSR_SEED_DEFAULT if seed==0;
- latch level;
- clear step_idx, the timeout counter and timeout.
REQ-017 The expected colour SHALL be lfsr[1:0] of the current LFSR state; step 0 uses the loaded seed.
REQ-018 The LFSR advance SHALL be: lfsr <= {lfsr[30:0], lfsr[31]^lfsr[21]^lfsr[1]^lfsr[0]}.
REQ-019 The LFSR SHALL advance exactly once per accepted correct press and at no other time.
REQ-020 In WAIT_BTN with btn_valid=1 and btn_color equal to the expected colour:
- if step_idx != latched level: increment step_idx, advance the LFSR, clear the timeout counter;
- if step_idx == latched level: enter PASS.
REQ-021 In WAIT_BTN with btn_valid=1 and a mismatched colour, the block SHALL enter FAIL with timeout=0.
REQ-022 In WAIT_BTN, the timeout counter SHALL increment every cycle without btn_valid; on reaching TIMEOUT_CYCLES-1, the block SHALL enter FAIL with timeout=1.
REQ-023 PASS and FAIL SHALL each last one cycle, assert pass or fail respectively, then return to IDLE.
REQ-024 busy SHALL be 1 in WAIT_BTN, PASS and FAIL, and 0 in IDLE.
REQ-025 start asserted in any non-IDLE state SHALL abort the round and reload as in REQ-016, with no pass or fail pulse emitted.
REQ-026 When start and btn_valid are both 1 in the same cycle, start SHALL win and the press SHALL be ignored.
REQ-027 btn_valid SHALL be ignored in IDLE, PASS and FAIL.
REQ-028 When a press and timeout expiry coincide, the press SHALL win.
REQ-029 A matching press with level=31 at step 31 SHALL produce pass, and step_idx SHALL NOT wrap.
REQ-030 All outputs SHALL be registered, with no combinational path from any input to any output.

Reset
REQ-031 While rst_n=0, the block SHALL asynchronously force all of the following:
- state to IDLE;
- lfsr to LFSR_SEED_DEFAULT;
- step_idx, busy, pass, fail, timeout and the timeout counter to 0.
REQ-032 Reset deassertion SHALL take effect synchronously, and the first start SHALL be honoured on the first rising edge after rst_n rises.
REQ-033 Reset asserted mid-round SHALL discard the round silently, with no pass or fail pulse.

Structure
REQ-034 The shared package simon_pkg SHALL hold:
- the FSM state enum;
- the 2-bit colour typedef;
- the tap positions 31, 21, 1 and 0;
- LFSR_SEED_DEFAULT.
REQ-035 The LFSR register and its feedback SHALL be one sub-module, seq_lfsr, with ports for load, load value, advance and state output; the checker FSM and the counters live in simon_seq_checker.

Verification
REQ-036 seed=32'h00000001, level=3, presses 1,3,2,1 -> pass pulses one cycle after the fourth press; step_idx reads 0,1,2,3; fail never asserts.
REQ-037 Same seed, level=3, presses 1,3,0 -> fail pulses after the third press with timeout=0; busy falls the cycle after fail.
REQ-038 TIMEOUT_CYCLES=16, seed=1, level=0, no press -> fail with timeout=1 exactly 16 cycles after entering WAIT_BTN.
REQ-039 seed=0, level=0, press 2 -> pass, because LFSR_SEED_DEFAULT[1:0]=2'b10.
REQ-040 After press 1 in a seed=1 round, start with seed=1 and btn_valid=1 (colour 3) in the same cycle -> round restarts at step_idx=0, no pass or fail pulse, next expected colour is 1.
REQ-041 rst_n pulsed low mid-round after two correct presses -> immediate IDLE, all outputs 0, no pulses.
